freq_div_arbiter: RTL
=====================

FREQ_DIV_ARBITER -- requirements
Module: freq_div_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of requesting counter channels (2..8).
REQ-002 Parameter DIV_LATENCY, default 3, edges from divider numerator sample to quotient valid.
REQ-003 Parameter CHW, default $clog2(NCH), channel index width.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clocked on clk.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req_valid  input  NCH  per-channel request: gate count ready for division.
REQ-007 req_data  input  NCH*32  per-channel gate count; channel i occupies bits [32*i+31:32*i].
REQ-008 req_ready  output  NCH  per-channel grant; at most one bit high per cycle.
REQ-009 div_numerator  output  32  registered numerator to the shared pipelined divider.
REQ-010 div_quotient  input  32  quotient returned by the shared divider.
REQ-011 rsp_valid  output  1  one-cycle pulse: rsp_ch/rsp_quotient valid.
REQ-012 rsp_ch  output  CHW  channel the current response belongs to.
REQ-013 rsp_quotient  output  32  registered quotient for rsp_ch.
REQ-014 busy  output  1  high while any granted request is in flight.

Function
REQ-015 Handshake: a transfer on channel i occurs at an edge where req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready SHALL be combinational from req_valid and the arbitration state; the block never stalls, so a grant is issued in every cycle in which any req_valid is high.
REQ-017 No request is dropped: a channel holding req_valid high without req_ready keeps its data until granted.
REQ-018 On a transfer at edge T, div_numerator SHALL load the granted req_data at T and hold it until the next transfer.
REQ-019 A tag shift register of depth DIV_LATENCY+1 SHALL carry {valid, channel} alongside each transfer.
REQ-020 rsp_valid, rsp_ch and rsp_quotient SHALL be registered at edge T+DIV_LATENCY+1, with rsp_quotient captured from div_quotient: 4 edges after the transfer at default latency.
REQ-021 Throughput: one transfer per cycle; back-to-back responses in consecutive cycles; order of responses equals order of grants.
REQ-022 rsp_quotient SHALL pass div_quotient unchanged, with no zero-value special case.
REQ-023 busy SHALL be the OR of all tag valid bits.
REQ-024 rsp_ch and rsp_quotient hold their last value when rsp_valid is low.
REQ-025 Channels whose req_valid is low are never granted; with no req_valid high, req_ready is all-zero and a zero-valid tag is shifted in.

Reset
REQ-026 While rst is high: req_ready=0, div_numerator=0, rsp_valid=0, rsp_ch=0, rsp_quotient=0, busy=0, all tags invalid, priority pointer=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight tags; no rsp_valid is produced for transfers granted before reset.
REQ-028 The first transfer after reset release may occur at the first edge with rst low.

Configuration
REQ-029 Macro FREQ_DIV_ARB_RR_EN defined: round-robin arbitration; after a grant to channel g, the highest priority moves to (g+1) mod NCH; the pointer is unchanged in cycles without a grant.
REQ-030 Macro FREQ_DIV_ARB_RR_EN undefined: fixed priority, with channel 0 highest and NCH-1 lowest; no pointer register.

Verification
(Bench divider stub: DIV_LATENCY-stage delay returning numerator+1.)
REQ-031 Single request: ch2 req_data=100 for one grant -> req_ready[2]=1 at T; rsp_valid at T+4 with rsp_ch=2 and rsp_quotient=101; busy high over T+1..T+4.
REQ-032 All four channels held valid with data 10,20,30,40 under RR_EN -> grants 0,1,2,3,0,...; responses 11,21,31,41 in consecutive cycles.
REQ-033 All four channels held valid without RR_EN -> ch0 granted every cycle; ch1..3 never granted while ch0 is valid.
REQ-034 RR_EN with the pointer at 3 and only ch1 valid -> ch1 granted; the pointer becomes 2.
REQ-035 Reset asserted 2 cycles after a transfer -> no rsp_valid for that transfer and all outputs equal reset values; a new request of 7 after release -> rsp_quotient=8.
REQ-036 req_data=0 -> rsp_quotient=1; req_data=32'hFFFFFFFF -> rsp_quotient=0 (stub wrap), passed through unmodified.

Source files
------------

// File: rtl/freq_div_arbiter.sv
// Arbitrates NCH gate-count channels onto one shared pipelined divider and returns tagged quotients.
// Define FREQ_DIV_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (channel 0 first).
module freq_div_arbiter #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIV_LATENCY = 3,
  parameter int unsigned CHW         = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*32-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic [31:0]       div_numerator,
  input  logic [31:0]       div_quotient,
  output logic              rsp_valid,
  output logic [CHW-1:0]    rsp_ch,
  output logic [31:0]       rsp_quotient,
  output logic              busy
);

  logic           gnt_any;
  logic [CHW-1:0] gnt_ch;
  logic [31:0]    gnt_data;

  logic [31:0]                     div_num_q;
  logic [DIV_LATENCY:0]            tag_vld_q;
  logic [DIV_LATENCY:0][CHW-1:0]   tag_ch_q;
  logic                            rsp_valid_q;
  logic [CHW-1:0]                  rsp_ch_q;
  logic [31:0]                     rsp_quot_q;

`ifdef FREQ_DIV_ARB_RR_EN
  localparam logic [CHW:0] NchW = (CHW+1)'(NCH);

  logic [CHW-1:0] ptr_q, ptr_d;

  // Scan channels starting at the pointer, wrapping modulo NCH.
  always_comb begin
    logic [CHW:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = {1'b0, ptr_q} + (CHW+1)'(k);
      if (idx >= NchW) idx = idx - NchW;
      if (!gnt_any && req_valid[idx[CHW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_ch  = idx[CHW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + CHW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_ch  = CHW'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_ch == CHW'(i)) gnt_data = req_data[32*i +: 32];
      req_ready[i] = !rst && gnt_any && (gnt_ch == CHW'(i));
    end
  end

  // Tags travel alongside the divider pipeline so each quotient is matched to its channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_num_q   <= '0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_quot_q  <= '0;
    end else begin
      if (gnt_any) div_num_q <= gnt_data;
      tag_vld_q   <= {tag_vld_q[DIV_LATENCY-1:0], gnt_any};
      tag_ch_q    <= {tag_ch_q[DIV_LATENCY-1:0], gnt_ch};
      rsp_valid_q <= tag_vld_q[DIV_LATENCY];
      if (tag_vld_q[DIV_LATENCY]) begin
        rsp_ch_q   <= tag_ch_q[DIV_LATENCY];
        rsp_quot_q <= div_quotient;
      end
    end
  end

  assign div_numerator = div_num_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_ch        = rsp_ch_q;
  assign rsp_quotient  = rsp_quot_q;
  assign busy          = |tag_vld_q;

endmodule
